// File: rtl/bist_datapath.sv
// bist_datapath: March-test address counter, memory strobes and read compare/fail log; define BIST_DIAG_EN to keep fail_cnt/ff_addr/ff_data
module bist_datapath #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          up_down,
  input  logic          rst_adr,
  input  logic          pr_res_adr,
  input  logic          data_bit,
  input  logic          wr_en,
  input  logic          read_en,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic          c_out,
  output logic          fail,
  output logic [7:0]    fail_cnt,
  output logic [AW-1:0] ff_addr,
  output logic [DW-1:0] ff_data
);
  logic [AW-1:0] cnt;
  logic          pend;
  logic [DW-1:0] exp_data;
  logic          term;
  logic          mismatch;
  assign term      = up_down ? &cnt : ~|cnt;
  assign mem_addr  = cnt;
  assign mem_wdata = {DW{data_bit}};
  assign mem_we    = wr_en;
  assign mem_re    = read_en & ~wr_en;
  assign mismatch  = pend && (mem_rdata != exp_data);
  // Address counter: start-of-march load beats a step; c_out flags the wrap one cycle later
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (rst_adr) cnt <= up_down ? '0 : '1;
    else if (enable) cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
    c_out <= ~rst & ~rst_adr & enable & term;
  end
  // Read pipeline: remember that a read is in flight and what it should return
  always_ff @(posedge clk) begin
    pend <= ~rst & mem_re;
    if (mem_re) exp_data <= mem_wdata;
  end
  // Sticky fail flag; a clear discards a mismatch in the same cycle
  always_ff @(posedge clk) begin
    if (rst || pr_res_adr) fail <= 1'b0;
    else if (mismatch) fail <= 1'b1;
  end
`ifdef BIST_DIAG_EN
  logic [AW-1:0] exp_addr;
  logic [7:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  // Address of the in-flight read, so counter moves cannot disturb the log
  always_ff @(posedge clk) begin
    if (mem_re) exp_addr <= cnt;
  end
  // Saturating mismatch count and first-fail capture
  always_ff @(posedge clk) begin
    if (rst || pr_res_adr) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (mismatch) begin
      if (cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
      if (!fail) begin
        addr_q <= exp_addr;
        data_q <= mem_rdata;
      end
    end
  end
  assign fail_cnt = cnt_q;
  assign ff_addr  = addr_q;
  assign ff_data  = data_q;
`else
  assign fail_cnt = '0;
  assign ff_addr  = '0;
  assign ff_data  = '0;
`endif
endmodule

// File: doc/bist_datapath.md
BIST_DATAPATH -- requirements
Module: bist_datapath

Interface
REQ-001: Parameter AW, default 4, memory address width in bits.
REQ-002: Parameter DW, default 8, memory data width in bits.
REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: enable  input  1  address counter step request from the BIST controller.
REQ-006: up_down  input  1  count direction: 1 = up, 0 = down.
REQ-007: rst_adr  input  1  counter start-of-march load strobe.
REQ-008: pr_res_adr  input  1  clear strobe for the fail log.
REQ-009: data_bit  input  1  background data bit, replicated to DW bits.
REQ-010: wr_en / read_en  input  1 each  memory write / read request.
REQ-011: mem_rdata  input  DW  memory read data, valid one cycle after mem_re.
REQ-012: mem_addr  output  AW  current counter value.
REQ-013: mem_wdata  output  DW  {DW{data_bit}}.
REQ-014: mem_we / mem_re  output  1 each  memory write / read strobes.
REQ-015: c_out  output  1  registered one-cycle pulse on counter wrap.
REQ-016: fail  output  1  sticky mismatch flag.
REQ-017: fail_cnt  output  8  saturating mismatch count.
REQ-018: ff_addr / ff_data  output  AW / DW  address and read data of the first mismatch.

Function
REQ-019: Counter priority SHALL be rst, then rst_adr, then enable.
- rst_adr loads 0 when up_down=1 and all-ones when up_down=0.
- enable steps the counter by +1 or -1 modulo 2^AW.
REQ-020: When enable=1, rst_adr=0, and the counter is at terminal (all-ones if up, 0 if down):
- the counter wraps;
- c_out SHALL be 1 in the following cycle only.
- c_out is 0 in every other cycle.
REQ-021: Memory strobes:
- mem_we = wr_en.
- mem_re = read_en & ~wr_en; write wins when both are asserted.
- mem_addr and mem_wdata are combinational from the counter and data_bit.
REQ-022: Read pipeline: when mem_re=1, the block SHALL register a pending flag, mem_addr, and mem_wdata as expected data.
REQ-023: Compare occurs in the next cycle (latency 1). Mismatch condition: pending=1 and mem_rdata != expected.
REQ-024: On mismatch with pr_res_adr=0:
- fail <= 1;
- fail_cnt increments, saturating at 255.
- If fail was 0 before this mismatch, ff_addr and ff_data capture the registered address and mem_rdata.
REQ-025: pr_res_adr=1 SHALL clear fail, fail_cnt, ff_addr and ff_data. It takes priority over a same-cycle mismatch, which is discarded. The read pipeline is unaffected.
REQ-026: Back-to-back reads on consecutive cycles SHALL each be compared, with no bubbles required.
REQ-027: rst_adr or an enable step SHALL NOT cancel a pending compare, because the compare uses the registered address.

Reset
REQ-028: On rst=1 the block SHALL set to zero, in the next cycle:
- the counter and c_out;
- the pending flag;
- fail and fail_cnt;
- ff_addr and ff_data.
REQ-029: rst asserted mid-operation SHALL discard any pending compare, so no fail results from the read issued in the reset cycle.
REQ-030: Combinational outputs SHALL follow their inputs during reset; mem_addr reads 0.

Configuration
REQ-031: Macro BIST_DIAG_EN.
- Defined: fail_cnt, ff_addr and ff_data SHALL behave per REQ-024/025.
- Undefined: fail_cnt, ff_addr and ff_data SHALL be constant 0 and their registers omitted; fail, c_out and the counter are unchanged.

Verification
REQ-032: Scenario 1 -- wrap up.
- Stimulus: rst, rst_adr with up_down=1, then 16 enable cycles.
- Response: mem_addr 0..15 then 0; c_out high exactly 1 cycle, right after the step from 15.
REQ-033: Scenario 2 -- wrap down.
- Stimulus: rst_adr with up_down=0, then enable.
- Response: mem_addr 15,14,...; c_out pulses once after the step from 0.
REQ-034: Scenario 3 -- clean read.
- Stimulus: read_en at addr 3 with data_bit=1; mem_rdata=8'hFF next cycle.
- Response: fail stays 0.
REQ-035: Scenario 4 -- mismatches, with BIST_DIAG_EN defined.
- Stimulus: read addr 5 with data_bit=0 and mem_rdata=8'h04; then read addr 9 and mismatch.
- Response: fail=1, fail_cnt=2, ff_addr=5, ff_data=8'h04.
REQ-036: Scenario 5 -- clear vs mismatch, and reset mid-read.
- pr_res_adr in the same cycle as a mismatch -> fail=0, fail_cnt=0.
- rst in the cycle of read_en with bad data next cycle -> fail=0.
REQ-037: Scenario 6 -- saturation and write priority.
- 300 consecutive mismatching reads -> fail_cnt=255.
- wr_en and read_en high together -> mem_re=0 and no compare.
